byte_serial_adder_ctrl: RTL and testbench
=========================================

# byte_serial_adder_ctrl

Byte-serial multi-byte add/subtract sequencer that drives the team's 8-bit ripple-carry adder stage. It accepts operand byte pairs LSB-first over a valid/ready handshake and presents each pair to the external 8-bit adder. It chains the adder's carry-out into the next byte's carry-in through a register, and returns registered sum bytes downstream with word-final carry and signed-overflow flags. It lets one 8-bit adder instance perform NBYTES×8-bit arithmetic at one byte per cycle.

## Interface
- NBYTES, 4, bytes per operand word; legal range 2..16.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand byte pair valid.
- in_ready  output  1  block can accept a byte pair this cycle.
- in_a  input  8  operand A byte, LSB-first order.
- in_b  input  8  operand B byte, LSB-first order.
- in_sub  input  1  1 = A−B, 0 = A+B; sampled only on the first byte of a word.
- add_a  output  8  to adder operand a.
- add_b  output  8  to adder operand b.
- add_cin  output  1  to adder carry-in.
- add_sum  input  8  from adder sum.
- add_cout  input  1  from adder carry-out.
- out_valid  output  1  sum byte valid.
- out_ready  input  1  downstream accepts sum byte.
- out_sum  output  8  registered sum byte.
- out_last  output  1  out_sum is byte NBYTES−1 of the word.
- out_cout  output  1  final carry-out, valid with out_last, else 0.
- out_ovf  output  1  signed overflow, valid with out_last, else 0.

## Operation
- Internal state:
  - byte counter cnt, width ceil(log2(NBYTES)).
  - carry_q, sub_q.
  - one-entry output register holding out_sum, out_last, out_cout, out_ovf and out_valid.
- Handshake:
  - in_ready = !out_valid || out_ready.
  - Accept occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- first = (cnt == 0). On a first byte, sub_eff = in_sub; otherwise sub_eff = sub_q.
- Adder drive is combinational from the inputs on every cycle, whether or not an accept occurs:
  - add_a = in_a.
  - add_b = in_b XOR {8{sub_eff}}.
  - add_cin = first ? in_sub : carry_q.
- On accept:
  - out_sum ← add_sum and out_valid ← 1.
  - out_last ← (cnt == NBYTES−1).
  - carry_q ← add_cout.
  - If first, sub_q ← in_sub.
  - cnt ← (cnt == NBYTES−1) ? 0 : cnt+1.
- On an accept of the last byte:
  - out_cout ← add_cout.
  - out_ovf ← (in_a[7] == add_b[7]) && (add_sum[7] != in_a[7]).
  - carry_q ← 0.
- On an accept of a non-last byte: out_cout ← 0 and out_ovf ← 0.
- Output transfer with no accept in the same cycle: out_valid ← 0. Register contents are held but don't care.
- Simultaneous transfer and accept: the output register is reloaded with the new byte and out_valid stays 1.
- Subtraction semantics:
  - out_cout = 1 means no borrow (A ≥ B unsigned).
  - out_ovf flags a two's-complement signed result out of range.
- Words are back-to-back. After the last byte, the next accepted byte is a first byte with no idle cycle required.
- in_sub on non-first bytes is ignored.

## Timing
- Reset (asynchronous, rst_n = 0) forces:
  - out_valid = 0, out_sum = 0x00, out_last = 0, out_cout = 0, out_ovf = 0.
  - cnt = 0, carry_q = 0, sub_q = 0.
- Reset release is synchronous to clk. The first accept can occur on the first rising edge with rst_n = 1.
- Latency: a byte accepted at edge N appears on out_* after edge N and stays there until transferred.
- Throughput: 1 byte/cycle while out_ready = 1. A full word takes NBYTES cycles.
- Backpressure:
  - out_valid && !out_ready ⇒ in_ready = 0.
  - out_*, cnt, carry_q and sub_q all hold.
- in_ready depends combinationally on out_ready. No other input-to-output combinational paths exist besides the adder drive.
- Reset mid-word discards the partial word. The next accept is a first byte with add_cin = in_sub.
- The adder path is purely combinational. It must settle within one clk period: 8 full-adder carry delays plus the XOR on b.

## Test plan
- NBYTES=4, add 0x000000FF + 0x00000001, out_ready=1 → out_sum 0x00,0x01,0x00,0x00 on consecutive cycles; out_last on the 4th; out_cout=0, out_ovf=0.
- Add 0xFFFFFFFF + 0x00000001 → four 0x00 bytes, out_cout=1, out_ovf=0. Then add 0x7FFFFFFF + 0x00000001 back-to-back → 0x00,0x00,0x00,0x80, out_cout=0, out_ovf=1.
- Subtract 0x00000000 − 0x00000001 → 0xFF ×4, out_cout=0 (borrow), out_ovf=0. Subtract 0x80000000 − 0x00000001 → 0xFF,0xFF,0xFF,0x7F, out_cout=1, out_ovf=1.
- Backpressure: out_ready=0 for 3 cycles after byte 1 of 0x000001FF + 0x00000001 → in_ready=0 and out_sum held at 0x00; on release the remaining bytes are 0x02,0x00,0x00 (carry preserved).
- Toggle in_sub on bytes 2–4 of an add word → result identical to in_sub=0 throughout (latched sub_q used).
- Assert rst_n low after 2 bytes accepted, mid-cycle → all outputs 0 immediately. Then the word 0x00000001 + 0x00000001 → 0x02,0x00,0x00,0x00, out_last on its 4th byte.

Source files
------------

// File: rtl/byte_serial_adder_ctrl.sv
// byte_serial_adder_ctrl: sequences LSB-first byte pairs through an external 8-bit adder to do NBYTES*8-bit add/sub
module byte_serial_adder_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_in_valid,
    output logic       o_in_ready,
    input  logic [7:0] i_in_a,
    input  logic [7:0] i_in_b,
    input  logic       i_in_sub,
    output logic [7:0] o_add_a,
    output logic [7:0] o_add_b,
    output logic       o_add_cin,
    input  logic [7:0] i_add_sum,
    input  logic       i_add_cout,
    output logic       o_out_valid,
    input  logic       i_out_ready,
    output logic [7:0] o_out_sum,
    output logic       o_out_last,
    output logic       o_out_cout,
    output logic       o_out_ovf
);
    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);
    logic [CW-1:0] r_cnt;
    logic          r_carry;
    logic          r_sub;
    logic          r_out_valid;
    logic [7:0]    r_out_sum;
    logic          r_out_last;
    logic          r_out_cout;
    logic          r_out_ovf;
    logic          w_first;
    logic          w_last;
    logic          w_sub_eff;
    logic          w_accept;
    logic          w_xfer;
    logic          w_ovf;
    always_comb begin
        w_first    = (r_cnt == '0);
        w_last     = (r_cnt == LAST);
        w_sub_eff  = w_first ? i_in_sub : r_sub;
        o_add_a    = i_in_a;
        o_add_b    = i_in_b ^ {8{w_sub_eff}};
        o_add_cin  = w_first ? i_in_sub : r_carry;
        o_in_ready = !r_out_valid || i_out_ready;
        w_accept   = i_in_valid && o_in_ready;
        w_xfer     = r_out_valid && i_out_ready;
        w_ovf      = (i_in_a[7] == o_add_b[7]) && (i_add_sum[7] != i_in_a[7]);
    end
    // Carry is cleared at the word boundary so the next word starts from in_sub alone.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_sub       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= 8'h00;
            r_out_last  <= 1'b0;
            r_out_cout  <= 1'b0;
            r_out_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_sum   <= i_add_sum;
            r_out_last  <= w_last;
            r_out_cout  <= w_last ? i_add_cout : 1'b0;
            r_out_ovf   <= w_last ? w_ovf : 1'b0;
            r_carry     <= w_last ? 1'b0 : i_add_cout;
            r_sub       <= w_first ? i_in_sub : r_sub;
            r_cnt       <= w_last ? '0 : r_cnt + 1'b1;
        end else if (w_xfer) begin
            r_out_valid <= 1'b0;
        end
    end
    assign o_out_valid = r_out_valid;
    assign o_out_sum   = r_out_sum;
    assign o_out_last  = r_out_last;
    assign o_out_cout  = r_out_cout;
    assign o_out_ovf   = r_out_ovf;
endmodule

// File: tb/tb_byte_serial_adder_ctrl.sv
// tb_byte_serial_adder_ctrl: directed and random words checked against a whole-word arithmetic model
module tb_byte_serial_adder_ctrl;
    localparam int NB = 4;
    typedef struct packed {
        logic [7:0] sum;
        logic       last;
        logic       cout;
        logic       ovf;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = 8'h00;
    logic [7:0] in_b = 8'h00;
    logic       in_sub = 1'b0;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic       add_cin;
    logic [7:0] add_sum;
    logic       add_cout;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_last;
    logic       out_cout;
    logic       out_ovf;
    logic       rnd_rdy = 1'b0;
    logic       rdy_rand = 1'b1;
    logic       force_rdy = 1'b1;
    logic       gaps = 1'b0;
    logic       mon_en = 1'b1;
    int         n_chk = 0;
    int         n_err = 0;
    exp_t       q[$];
    always #5 clk = ~clk;
    assign out_ready = rnd_rdy ? rdy_rand : force_rdy;
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};
    byte_serial_adder_ctrl #(.NBYTES(NB)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_in_a(in_a), .i_in_b(in_b), .i_in_sub(in_sub),
        .o_add_a(add_a), .o_add_b(add_b), .o_add_cin(add_cin),
        .i_add_sum(add_sum), .i_add_cout(add_cout),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_sum(out_sum), .o_out_last(out_last),
        .o_out_cout(out_cout), .o_out_ovf(out_ovf)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask
    always @(posedge clk) begin
        #1 rdy_rand = ($urandom_range(0, 3) != 0);
    end
    always @(negedge clk) begin
        if (mon_en && rst_n && out_valid) begin
            if (!out_ready) chk("bp_in_ready", 32'(in_ready), 0);
            else if (q.size() == 0) chk("unexpected_out", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("out_sum", 32'(out_sum), 32'(e.sum));
                chk("out_last", 32'(out_last), 32'(e.last));
                chk("out_cout", 32'(out_cout), 32'(e.cout));
                chk("out_ovf", 32'(out_ovf), 32'(e.ovf));
            end
        end
    end
    task automatic push_model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        longint ua, ub, sa, sb, r, u;
        logic [31:0] res;
        logic c, v;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        u = sub ? ua - ub : ua + ub;
        r = sub ? sa - sb : sa + sb;
        res = u[31:0];
        c = sub ? (ua >= ub) : (u > 64'sh0FFFF_FFFF);
        v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        for (int i = 0; i < NB; i++) begin
            exp_t e;
            e.sum = res[8*i +: 8];
            e.last = (i == NB - 1);
            e.cout = e.last ? c : 1'b0;
            e.ovf = e.last ? v : 1'b0;
            q.push_back(e);
        end
    endtask
    task automatic send_word(input logic [31:0] a, input logic [31:0] b, input logic sub);
        push_model(a, b, sub);
        for (int i = 0; i < NB; i++) begin
            int t;
            if (gaps) repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_a = a[8*i +: 8];
            in_b = b[8*i +: 8];
            in_sub = (i == 0) ? sub : 1'($urandom);
            t = 0;
            @(negedge clk);
            while (!in_ready && t < 1000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 1000) chk("accept_timeout", 1, 0);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask
    task automatic drain();
        int t;
        t = 0;
        @(negedge clk);
        while ((q.size() != 0 || out_valid) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) chk("drain_timeout", 32'(q.size()), 0);
        @(posedge clk);
        #1;
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_sum", 32'(out_sum), 0);
        chk("rst_last", 32'(out_last), 0);
        chk("rst_cout_ovf", 32'({out_cout, out_ovf}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_word(32'h0000_00FF, 32'h0000_0001, 1'b0);
        send_word(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        send_word(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        send_word(32'h0000_0000, 32'h0000_0001, 1'b1);
        send_word(32'h8000_0000, 32'h0000_0001, 1'b1);
        drain();
        force_rdy = 1'b0;
        fork
            send_word(32'h0000_01FF, 32'h0000_0001, 1'b0);
            begin
                int t;
                t = 0;
                @(negedge clk);
                while (!out_valid && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                chk("bp_first_valid", 32'(out_valid), 1);
                for (int i = 0; i < 3; i++) begin
                    if (i > 0) @(negedge clk);
                    chk("bp_hold_ready", 32'(in_ready), 0);
                    chk("bp_hold_sum", 32'(out_sum), 32'h00);
                end
                @(posedge clk);
                #1 force_rdy = 1'b1;
            end
        join
        drain();
        mon_en = 1'b0;
        in_valid = 1'b1;
        in_a = 8'h11;
        in_b = 8'h22;
        in_sub = 1'b0;
        @(posedge clk);
        #1 in_a = 8'h33;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_sum", 32'(out_sum), 0);
        chk("mid_rst_flags", 32'({out_last, out_cout, out_ovf}), 0);
        in_valid = 1'b0;
        in_sub = 1'b1;
        in_b = 8'h0F;
        #1;
        chk("mid_rst_cin", 32'(add_cin), 1);
        chk("mid_rst_addb", 32'(add_b), 32'hF0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        in_sub = 1'b0;
        send_word(32'h0000_0001, 32'h0000_0001, 1'b0);
        drain();
        rnd_rdy = 1'b1;
        gaps = 1'b1;
        for (int w = 0; w < 150; w++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: a = 32'h0000_0000;
                1: a = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: a = 32'h7FFF_FFFF;
                default: ;
            endcase
            if ($urandom_range(0, 5) == 0) b = a;
            if ($urandom_range(0, 2) == 0) gaps = ~gaps;
            send_word(a, b, 1'($urandom));
        end
        drain();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
